// File: rtl/tag_comparator.sv
// Tag comparator: pops a request from the tag FIFO, checks the metadata beat
// returned on the R channel, and reports hit/dirty with hit/miss statistics.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 64
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 16
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 10
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 6
`endif

module tag_comparator #(
  parameter int ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int TID_WIDTH    = `TID_WIDTH,
  parameter int INDEX_WIDTH  = `INDEX_WIDTH,
  parameter int OFFSET_WIDTH = `OFFSET_WIDTH,
  parameter int DATA_WIDTH   = 512
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tag_fifo_empty_i,
  input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_data_i,
  output logic                              tag_fifo_rden_o,
  input  logic [DATA_WIDTH-1:0]             rdata_i,
  input  logic                              rlast_i,
  input  logic                              rvalid_i,
  output logic                              rready_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic [ADDR_WIDTH+TID_WIDTH+2:0]   res_o,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       miss_cnt_o
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int ENT_WIDTH = ADDR_WIDTH + TID_WIDTH + 1;
  localparam int RES_WIDTH = ENT_WIDTH + 2;
  localparam int TAG_LSB   = OFFSET_WIDTH + INDEX_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_R,
    S_OUT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ENT_WIDTH-1:0] entry;
  logic [RES_WIDTH-1:0] res_q;
  logic                 first;
  logic                 meta_hit;
  logic                 meta_dirty;
  logic [31:0]          hit_cnt;
  logic [31:0]          miss_cnt;

  logic [TAG_WIDTH-1:0] req_tag;
  logic [TAG_WIDTH-1:0] beat_tag;
  logic                 beat_valid;
  logic                 beat_dirty;
  logic                 beat_hit;
  logic                 beat_acc;
  logic                 hit_eval;
  logic                 dirty_eval;
  logic                 handshake;
  logic                 unused_rdata;

  assign req_tag    = entry[ADDR_WIDTH-1:TAG_LSB];
  assign beat_tag   = rdata_i[TAG_WIDTH-1:0];
  assign beat_valid = rdata_i[TAG_WIDTH];
  assign beat_dirty = rdata_i[TAG_WIDTH+1];
  assign beat_hit   = beat_valid & (beat_tag == req_tag);

  assign unused_rdata = ^rdata_i[DATA_WIDTH-1:TAG_WIDTH+2];

  assign beat_acc  = rready_o & rvalid_i;
  assign handshake = res_valid_o & res_ready_i;

  // Only the first accepted beat carries the metadata that decides the result.
  assign hit_eval   = first ? beat_hit : meta_hit;
  assign dirty_eval = first ? (beat_dirty & beat_valid) : meta_dirty;

  always_comb begin
    state_nx        = state;
    tag_fifo_rden_o = 1'b0;
    rready_o        = 1'b0;
    res_valid_o     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!tag_fifo_empty_i) begin
          tag_fifo_rden_o = 1'b1;
          state_nx        = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) begin
          state_nx = S_OUT;
        end
      end
      S_OUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (!rst_n) begin
      tag_fifo_rden_o = 1'b0;
      rready_o        = 1'b0;
      res_valid_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      entry      <= '0;
      first      <= 1'b0;
      meta_hit   <= 1'b0;
      meta_dirty <= 1'b0;
      res_q      <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (tag_fifo_rden_o) begin
        entry <= tag_fifo_data_i;
        first <= 1'b1;
      end
      if (beat_acc && first) begin
        first      <= 1'b0;
        meta_hit   <= hit_eval;
        meta_dirty <= dirty_eval;
      end
      if (beat_acc && rlast_i) begin
        res_q <= {hit_eval, dirty_eval, entry};
      end
      if (handshake) begin
        if (res_q[RES_WIDTH-1]) begin
          if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end

  assign res_o      = res_q;
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule
